// File: rtl/nms_window_feeder_if.sv
// Score-in / window-out bundle between the FAST score stage, the feeder and the NMS datapath.
// master = the feeder itself; slave = the surrounding score source and window consumer.
interface nms_window_feeder_if #(
   parameter int ADDR_W = 15
);
   logic                frame_start;
   logic [7:0]          score_in;
   logic                score_valid;
   logic                score_ready;
   logic                win_valid;
   logic                win_ready;
   logic [7:0]          refScore;
   logic [63:0]         adjScore;
   logic [ADDR_W-1:0]   refAddr;
   logic                frame_done;

   modport master (
      input  frame_start, score_in, score_valid, win_ready,
      output score_ready, win_valid, refScore, adjScore, refAddr, frame_done
   );

   modport slave (
      output frame_start, score_in, score_valid, win_ready,
      input  score_ready, win_valid, refScore, adjScore, refAddr, frame_done
   );
endinterface

// File: rtl/nms_window_feeder.sv
// Raster score stream -> 3x3 NMS windows via two line buffers; window registered 1 cycle after accept.
// Backpressure: a held window (win_valid && !win_ready) stalls score_ready combinationally.
module nms_window_feeder #(
   parameter int IMG_W  = 181,
   parameter int IMG_H  = 181,
   parameter int ADDR_W = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   nms_window_feeder_if.master bus
);
   localparam int                COL_W    = $clog2(IMG_W);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] EDGE     = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   logic [7:0]        r_line0 [IMG_W];
   logic [7:0]        r_line1 [IMG_W];
   logic [7:0]        r_win   [3][3];
   logic [ADDR_W-1:0] r_col;
   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_addr;
   logic              r_win_vld;
   logic              r_frame_done;
   logic [7:0]        r_ref_score;
   logic [63:0]       r_adj_score;
   logic [ADDR_W-1:0] r_ref_addr;

   logic              w_score_rdy;
   logic              w_accept;
   logic [ADDR_W-1:0] w_col;
   logic [ADDR_W-1:0] w_row;
   logic [ADDR_W-1:0] w_addr;
   logic [COL_W-1:0]  w_col_idx;
   logic [7:0]        w_up2;
   logic [7:0]        w_up1;
   logic              w_interior;
   logic              w_last_col;
   logic              w_last_pix;

   assign w_score_rdy = reset_n && (!r_win_vld || bus.win_ready);
   assign w_accept    = bus.score_valid && w_score_rdy;

   // A frame_start pulse makes the coincident score land at (0,0).
   assign w_col      = bus.frame_start ? '0 : r_col;
   assign w_row      = bus.frame_start ? '0 : r_row;
   assign w_addr     = bus.frame_start ? '0 : r_addr;
   assign w_col_idx  = w_col[COL_W-1:0];
   assign w_up2      = r_line1[w_col_idx];
   assign w_up1      = r_line0[w_col_idx];
   assign w_interior = (w_row >= EDGE) && (w_col >= EDGE);
   assign w_last_col = (w_col == LAST_COL);
   assign w_last_pix = w_last_col && (w_row == LAST_ROW);

   // Line buffers are always rewritten before they feed an emitted window, so no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_line1[w_col_idx] <= w_up1;
         r_line0[w_col_idx] <= bus.score_in;
      end
   end

   // Window row 0 holds row-2, row 2 the current row; column 2 is the newest.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               r_win[i][j] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int i = 0; i < 3; i++) begin
            r_win[i][0] <= r_win[i][1];
            r_win[i][1] <= r_win[i][2];
         end
         r_win[0][2] <= w_up2;
         r_win[1][2] <= w_up1;
         r_win[2][2] <= bus.score_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (w_accept) begin
         if (w_last_pix) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
         end else if (w_last_col) begin
            r_col  <= '0;
            r_row  <= w_row + ONE;
            r_addr <= w_addr + ONE;
         end else begin
            r_col  <= w_col + ONE;
            r_addr <= w_addr + ONE;
         end
      end else if (bus.frame_start) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end
   end

   // Window outputs take the post-shift view: center is the old middle-right cell.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_win_vld    <= 1'b0;
         r_frame_done <= 1'b0;
         r_ref_score  <= '0;
         r_adj_score  <= '0;
         r_ref_addr   <= '0;
      end else begin
         r_frame_done <= w_accept && w_last_pix;
         if (w_accept && w_interior) begin
            r_win_vld   <= 1'b1;
            r_ref_score <= r_win[1][2];
            r_adj_score <= {r_win[0][1], r_win[0][2], w_up2,
                            r_win[1][1], w_up1,
                            r_win[2][1], r_win[2][2], bus.score_in};
            r_ref_addr  <= w_addr;
         end else if (bus.frame_start || bus.win_ready) begin
            r_win_vld   <= 1'b0;
         end
      end
   end

   assign bus.score_ready = w_score_rdy;
   assign bus.win_valid   = r_win_vld;
   assign bus.refScore    = r_ref_score;
   assign bus.adjScore    = r_adj_score;
   assign bus.refAddr     = r_ref_addr;
   assign bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_nms_window_feeder.sv
// Random-handshake bench for nms_window_feeder; expected windows are built from a stored image array.
module tb_nms_window_feeder;
   localparam int W    = 181;
   localparam int H    = 181;
   localparam int AW   = 15;
   localparam int NPIX = W * H;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   nms_window_feeder_if #(.ADDR_W(AW)) bus ();

   nms_window_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int          addr;
      logic [7:0]  ctr;
      logic [63:0] adj;
   } win_t;

   win_t       q[$];
   logic [7:0] img [NPIX];
   int         m_addr, total, bad, win_cnt, prev_hs, pat, acc_cnt;
   bit         exp_done, saw_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Neighbourhood of the pixel one row up and one column left of the newest pixel a.
   function automatic win_t make_win(input int a);
      win_t w;
      int   c;
      c     = a - W - 1;
      w.addr = a;
      w.ctr  = img[c];
      w.adj  = {img[c-W-1], img[c-W], img[c-W+1],
                img[c-1],             img[c+1],
                img[c+W-1], img[c+W], img[c+W+1]};
      return w;
   endfunction

   function automatic logic [7:0] score_for(input int a);
      case (pat)
         1:       return 8'(a % 256);
         2:       return (a == 10000) ? 8'd50 : 8'd0;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic cyc(input bit v, input bit [7:0] s, input bit wr, input bit fs);
      bit exp_vld, acc;
      int a;
      bus.score_valid = v;
      bus.score_in    = s;
      bus.win_ready   = wr;
      bus.frame_start = fs;
      @(negedge clk);
      exp_vld = (q.size() > 0);
      chk("score_ready", 64'(bus.score_ready), 64'(!exp_vld || wr));
      chk("win_valid",   64'(bus.win_valid),   64'(exp_vld));
      chk("frame_done",  64'(bus.frame_done),  64'(exp_done));
      if (exp_vld) begin
         chk("refAddr",  64'(bus.refAddr),  64'(q[0].addr));
         chk("refScore", 64'(bus.refScore), 64'(q[0].ctr));
         chk("adjScore", bus.adjScore,      q[0].adj);
      end
      if (bus.frame_done) begin
         saw_done = 1'b1;
         chk("win_count", 64'(win_cnt + 1), 64'((W - 2) * (H - 2)));
         chk("last_addr", 64'(bus.refAddr), 64'(NPIX - 1));
      end
      if (exp_vld && wr) begin
         if (prev_hs < 0)
            chk("first_win", 64'(bus.refAddr), 64'(2 * W + 2));
         if (prev_hs == 3 * W - 1)
            chk("row3_first", 64'(bus.refAddr), 64'(3 * W + 2));
         if (pat == 1 && q[0].addr == 2 * W + 2) begin
            chk("ramp_ref",    64'(bus.refScore),       64'd182);
            chk("ramp_adj_tl", 64'(bus.adjScore[63:56]), 64'd0);
            chk("ramp_adj_br", 64'(bus.adjScore[7:0]),   64'd108);
         end
         if (pat == 2 && q[0].addr == 10182) begin
            chk("spot_ctr", 64'(bus.refScore), 64'd50);
            chk("spot_adj", bus.adjScore, 64'd0);
         end
         if (pat == 2 && q[0].addr == 10000)
            chk("spot_br", bus.adjScore, 64'h0000_0000_0000_0032);
         if (pat == 2 && q[0].addr == 10364)
            chk("spot_tl", bus.adjScore, 64'h3200_0000_0000_0000);
         prev_hs = q[0].addr;
         win_cnt++;
         if (q[0].addr == NPIX - 1) begin
            prev_hs = -1;
            win_cnt = 0;
         end
         void'(q.pop_front());
      end
      if (fs) begin
         q.delete();
         m_addr  = 0;
         prev_hs = -1;
         win_cnt = 0;
      end
      exp_done = 1'b0;
      acc = v && (!exp_vld || wr);
      if (acc) begin
         a = m_addr;
         img[a] = s;
         if (a / W >= 2 && a % W >= 2) q.push_back(make_win(a));
         if (a == NPIX - 1) begin
            exp_done = 1'b1;
            m_addr   = 0;
         end else begin
            m_addr = a + 1;
         end
         acc_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      bus.score_valid = 1'b0;
      bus.score_in    = '0;
      bus.win_ready   = 1'b0;
      bus.frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready",  64'(bus.score_ready), 64'd0);
      chk("rst_valid",  64'(bus.win_valid),   64'd0);
      chk("rst_done",   64'(bus.frame_done),  64'd0);
      chk("rst_ref",    64'(bus.refScore),    64'd0);
      chk("rst_adj",    bus.adjScore,         64'd0);
      chk("rst_addr",   64'(bus.refAddr),     64'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_ready_after", 64'(bus.score_ready), 64'd1);
      q.delete();
      m_addr   = 0;
      exp_done = 1'b0;
      prev_hs  = -1;
      win_cnt  = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int vpct, input int rpct, input int hold_at);
      bit v, wr;
      saw_done = 1'b0;
      for (int n = 0; n < 60000 && !saw_done; n++) begin
         v  = ($urandom_range(99) < vpct);
         wr = (n >= hold_at && n < hold_at + 5) ? 1'b0 : ($urandom_range(99) < rpct);
         cyc(v, score_for(m_addr), wr, 1'b0);
      end
      chk("frame_seen", 64'(saw_done), 64'd1);
   endtask

   task automatic run_accepts(input int n, input int vpct, input int rpct);
      int start;
      start = acc_cnt;
      for (int k = 0; k < 20000 && acc_cnt - start < n; k++)
         cyc($urandom_range(99) < vpct, score_for(m_addr), $urandom_range(99) < rpct, 1'b0);
      chk("accept_budget", 64'(acc_cnt - start >= n), 64'd1);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      acc_cnt = 0;
      pat     = 0;
      do_reset();

      // Ramp frame, continuous valid, one 5-cycle downstream stall mid-frame.
      pat = 1;
      run_frame(100, 100, 5000);

      // Partial random frame, then restart with a coincident score accept.
      pat = 0;
      run_accepts(1000, 80, 80);
      pat = 2;
      cyc(1'b1, score_for(0), 1'b0, 1'b1);
      chk("fs_drop", 64'(bus.win_valid), 64'd0);

      // Single spot on a zero field under random handshakes.
      run_frame(90, 90, -100);

      // Reset in the middle of a frame, then restart streaming.
      pat = 0;
      run_accepts(500, 90, 90);
      do_reset();
      run_accepts(400, 90, 90);
      repeat (3) cyc(1'b0, 8'd0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
